// File: rtl/turbo_itl_sched.sv
// rtl/turbo_itl_sched.sv - turbo RX interleave/deinterleave pass sequencer
// Issues alternating interleave/deinterleave read passes per decoder iteration.
module turbo_itl_sched #(
    parameter int BEATS_PB16  = 16,
    parameter int BEATS_PB136 = 136,
    parameter int BEATS_PB520 = 520,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_rdy,
    input  logic [1:0] pb_size,
    input  logic [3:0] num_iter,
    input  logic       abort,
    input  logic       itl_dout_vld,
    output logic       itl_start,
    output logic       itl_mode,
    output logic       busy,
    output logic [3:0] iter_idx,
    output logic       pass_done,
    output logic       job_done,
    output logic [1:0] err
);
    localparam int TO_W  = $clog2(TIMEOUT) + 1;
    localparam int GAP_W = ($clog2(GAP_CYC + 1) > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TO_W-1:0]  TO_MAX   = '1;
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_GAP,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [3:0]        iter_q, iter_d;
    logic [3:0]        niter_q, niter_d;
    logic [9:0]        target_q, target_d;
    logic [9:0]        beat_q, beat_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              pass_q, pass_d;
    logic [1:0]        err_q, err_d;
    logic [9:0]        beat_inc;
    logic [TO_W-1:0]   to_inc;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        iter_d   = iter_q;
        niter_d  = niter_q;
        target_d = target_q;
        beat_d   = beat_q;
        to_d     = to_q;
        gap_d    = gap_q;
        pass_d   = 1'b0;
        err_d    = err_q;
        beat_inc = beat_q + 10'd1;
        to_inc   = (to_q == TO_MAX) ? to_q : to_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (frame_rdy) begin
                    err_d   = 2'd0;
                    niter_d = (num_iter == 4'd0) ? 4'd1 : num_iter;
                    case (pb_size)
                        2'd0:    target_d = 10'(BEATS_PB16);
                        2'd1:    target_d = 10'(BEATS_PB136);
                        default: target_d = 10'(BEATS_PB520);
                    endcase
                    if (pb_size == 2'd3) begin
                        err_d = 2'd1;
                    end else begin
                        iter_d  = 4'd0;
                        mode_d  = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                beat_d  = 10'd0;
                to_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (itl_dout_vld) begin
                    beat_d = beat_inc;
                    to_d   = '0;
                    if (beat_inc == target_q) begin
                        pass_d  = 1'b1;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else begin
                    to_d = to_inc;
                    if (to_inc >= TO_LIM) begin
                        err_d   = 2'd2;
                        mode_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                // First GAP cycle carries pass_done; GAP_CYC turnaround cycles follow it.
                if (gap_q == GAP_LAST) begin
                    if (mode_q) begin
                        mode_d  = 1'b0;
                        state_d = S_START;
                    end else if (({1'b0, iter_q} + 5'd1) < {1'b0, niter_q}) begin
                        iter_d  = iter_q + 4'd1;
                        mode_d  = 1'b1;
                        state_d = S_START;
                    end else begin
                        mode_d  = 1'b0;
                        state_d = S_FIN;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            err_d   = 2'd3;
            mode_d  = 1'b0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            iter_q   <= 4'd0;
            niter_q  <= 4'd0;
            target_q <= 10'd0;
            beat_q   <= 10'd0;
            to_q     <= '0;
            gap_q    <= '0;
            pass_q   <= 1'b0;
            err_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            iter_q   <= iter_d;
            niter_q  <= niter_d;
            target_q <= target_d;
            beat_q   <= beat_d;
            to_q     <= to_d;
            gap_q    <= gap_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
        end
    end

    assign itl_start = (state_q == S_START);
    assign itl_mode  = mode_q;
    assign busy      = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_GAP);
    assign iter_idx  = iter_q;
    assign pass_done = pass_q;
    assign job_done  = (state_q == S_FIN) && !abort;
    assign err       = err_q;
endmodule

// File: tb/tb_turbo_itl_sched.sv
// tb/tb_turbo_itl_sched.sv - scoreboard bench for turbo_itl_sched
module tb_turbo_itl_sched;
    localparam int TIMEOUT = 1024;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_rdy = 1'b0;
    logic [1:0] pb_size = 2'd0;
    logic [3:0] num_iter = 4'd0;
    logic       abort = 1'b0;
    logic       itl_dout_vld = 1'b0;
    logic       itl_start, itl_mode, busy, pass_done, job_done;
    logic [3:0] iter_idx;
    logic [1:0] err;

    turbo_itl_sched dut (
        .clk          (clk),
        .rst          (rst),
        .frame_rdy    (frame_rdy),
        .pb_size      (pb_size),
        .num_iter     (num_iter),
        .abort        (abort),
        .itl_dout_vld (itl_dout_vld),
        .itl_start    (itl_start),
        .itl_mode     (itl_mode),
        .busy         (busy),
        .iter_idx     (iter_idx),
        .pass_done    (pass_done),
        .job_done     (job_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // kind: 0 = start pulse, 1 = pass_done, 2 = job_done
    typedef struct {
        int kind;
        int mode;
        int iter;
    } ev_t;

    ev_t exp_q[$];
    int  pass_cyc_q[$];

    function automatic int tgt(input int pb);
        return (pb == 0) ? 16 : (pb == 1) ? 136 : 520;
    endfunction

    function automatic int job_len(input int pb, input int n);
        int ni = (n == 0) ? 1 : n;
        return 2 * ni * (1 + tgt(pb) + 1 + GAP_CYC) + 1;
    endfunction

    // Reference job: each iteration is interleave then deinterleave, then one job_done.
    function automatic void push_job(input int n, input bit start_only);
        int  ni = (n == 0) ? 1 : n;
        ev_t e;
        if (start_only) begin
            e = '{0, 1, 0};
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < ni; i++) begin
            for (int m = 1; m >= 0; m--) begin
                e = '{0, m, i};
                exp_q.push_back(e);
                e = '{1, 0, 0};
                exp_q.push_back(e);
            end
        end
        e = '{2, 0, 0};
        exp_q.push_back(e);
    endfunction

    // Interleaver model: beats begin the cycle after the start pulse, stop at target.
    int drv_pat = 0;
    int drv_stop = -1;
    int drv_target = 16;
    bit drv_abort = 1'b0;
    int job_seq = 0;
    int drv_last_beat = 0;
    int drv_abort_cyc = 0;
    int d_sent = 0;
    int d_seq = 0;
    bit d_active = 1'b0;
    bit d_first = 1'b0;
    bit d_tog = 1'b0;

    always @(negedge clk) begin
        bit b;
        abort = 1'b0;
        if (rst) begin
            d_active     = 1'b0;
            itl_dout_vld = 1'b0;
        end else if (itl_start) begin
            d_active     = 1'b1;
            d_sent       = 0;
            d_tog        = 1'b0;
            d_first      = (d_seq != job_seq);
            d_seq        = job_seq;
            itl_dout_vld = 1'b0;
        end else if (d_active) begin
            case (drv_pat)
                0: b = 1'b1;
                1: begin
                    b     = d_tog;
                    d_tog = !d_tog;
                end
                default: b = 1'($urandom_range(0, 1));
            endcase
            if (d_first && drv_stop >= 0 && d_sent == drv_stop) b = 1'b0;
            itl_dout_vld = b;
            if (b) begin
                d_sent++;
                drv_last_beat = cyc;
                if (d_sent == drv_target) begin
                    d_active = 1'b0;
                    if (d_first && drv_abort) begin
                        abort         = 1'b1;
                        drv_abort_cyc = cyc;
                    end else begin
                        pass_cyc_q.push_back(cyc + 1);
                    end
                end
            end
        end else begin
            itl_dout_vld = 1'b0;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        int  pc;
        if (!rst) begin
            if (itl_start) begin
                if (exp_q.size() == 0) chk("unexpected_start", int'(itl_start), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("start_order", 0, e.kind);
                    chk("start_mode", int'(itl_mode), e.mode);
                    chk("start_iter", int'(iter_idx), e.iter);
                    chk("start_busy", int'(busy), 1);
                end
            end
            if (pass_done) begin
                if (exp_q.size() == 0) chk("unexpected_pass", int'(pass_done), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("pass_order", 1, e.kind);
                end
                if (pass_cyc_q.size() == 0) chk("pass_unscheduled", int'(pass_done), 0);
                else begin
                    pc = pass_cyc_q.pop_front();
                    chk("pass_cycle", cyc, pc);
                end
            end
            if (job_done) begin
                if (exp_q.size() == 0) chk("unexpected_job_done", int'(job_done), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("job_order", 2, e.kind);
                    chk("job_busy", int'(busy), 0);
                end
            end
        end
    end

    int acc_cyc = 0;

    task automatic start_job(input int pb, input int n, input int pat, input int stop, input bit ab);
        drv_pat    = pat;
        drv_stop   = stop;
        drv_abort  = ab;
        drv_target = tgt(pb);
        job_seq++;
        @(negedge clk);
        frame_rdy = 1'b1;
        pb_size   = 2'(pb);
        num_iter  = 4'(n);
        acc_cyc   = cyc;
        @(negedge clk);
        frame_rdy = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            if (job_done) begin
                when = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("job_done_seen", int'(when >= 0), 1);
    endtask

    task automatic wait_idle(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                when = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("idle_seen", int'(when >= 0), 1);
    endtask

    initial begin
        int w;
        int pb;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({itl_start, itl_mode, busy, iter_idx, pass_done, job_done, err}), 0);
        rst = 1'b0;
        @(negedge clk);

        push_job(1, 1'b0);
        start_job(0, 1, 0, -1, 1'b0);
        wait_done(500, w);
        chk("len_pb16_n1", w - acc_cyc, job_len(0, 1));
        chk("err_pb16_n1", int'(err), 0);

        push_job(3, 1'b0);
        start_job(2, 3, 1, -1, 1'b0);
        wait_done(8000, w);
        chk("err_pb520_n3", int'(err), 0);
        chk("iter_final_pb520_n3", int'(iter_idx), 2);

        start_job(3, 5, 0, -1, 1'b0);
        chk("err_bad_pb", int'(err), 1);
        chk("busy_bad_pb", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("err_bad_pb_sticky", int'(err), 1);

        push_job(2, 1'b1);
        start_job(1, 2, 0, 100, 1'b0);
        wait_idle(3000, w);
        chk("err_timeout", int'(err), 2);
        chk("timeout_cycle", w, drv_last_beat + 1 + TIMEOUT);
        repeat (3) @(negedge clk);
        chk("err_timeout_sticky", int'(err), 2);

        push_job(1, 1'b0);
        start_job(1, 1, 0, -1, 1'b0);
        chk("err_cleared_on_accept", int'(err), 0);
        wait_done(600, w);
        chk("len_pb136_n1", w - acc_cyc, job_len(1, 1));

        push_job(2, 1'b1);
        start_job(0, 2, 0, -1, 1'b1);
        repeat (2) @(negedge clk);
        frame_rdy = 1'b1;
        pb_size   = 2'd3;
        num_iter  = 4'd7;
        @(negedge clk);
        frame_rdy = 1'b0;
        chk("busy_frame_rdy_ignored_err", int'(err), 0);
        chk("busy_frame_rdy_ignored_busy", int'(busy), 1);
        wait_idle(100, w);
        chk("err_abort", int'(err), 3);
        chk("abort_cycle", w, drv_abort_cyc + 1);
        repeat (4) @(negedge clk);

        push_job(0, 1'b0);
        start_job(0, 0, 0, -1, 1'b0);
        wait_done(500, w);
        chk("len_num_iter0", w - acc_cyc, job_len(0, 0));

        push_job(1, 1'b1);
        start_job(1, 1, 0, -1, 1'b0);
        repeat (20) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_run_outputs", int'({itl_start, itl_mode, busy, iter_idx, pass_done, job_done, err}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            pb = int'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 3));
            push_job(n, 1'b0);
            start_job(pb, n, 2, -1, 1'b0);
            wait_done(6000, w);
            chk("err_random_job", int'(err), 0);
            chk("iter_final_random_job", int'(iter_idx), n - 1);
        end

        repeat (5) @(negedge clk);
        chk("events_outstanding", exp_q.size(), 0);
        chk("pass_timing_outstanding", pass_cyc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
